// File: rtl/fp_result_packer.sv
// Packs 32-bit FP results into LINE_WORDS-wide memory lines; flush closes a zero-padded partial line.
// Optional FP_RESULT_PACKER_STATS_EN adds accepted-word and transferred-line counters.
module fp_result_packer #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned LINE_WIDTH = 32 * LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           fp_in,
    input  logic                  fp_in_valid,
    output logic                  fp_in_ready,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [LINE_WIDTH-1:0] line_out,
    output logic [4:0]            line_words,
    output logic                  line_valid,
    input  logic                  line_ready
`ifdef FP_RESULT_PACKER_STATS_EN
    ,
    output logic [31:0]           stat_words_in,
    output logic [31:0]           stat_lines_out
`endif
);

    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);

    typedef enum logic {FILL, FLUSH_PEND} state_t;

    state_t                state;
    logic [LINE_WIDTH-1:0] pack;
    logic [LINE_WIDTH-1:0] pack_nxt;
    logic [CNT_W-1:0]      word_cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  slot_free;
    logic                  accept;

    // The output register can take a new line if empty or being drained this cycle.
    assign slot_free   = !line_valid || line_ready;
    assign fp_in_ready = rst_n && (state == FILL) && ((word_cnt != LAST_IDX) || slot_free);
    assign accept      = fp_in_valid && fp_in_ready;

    // Pack contents and count after this cycle's accept, before any line is closed.
    always_comb begin
        pack_nxt = pack;
        cnt_nxt  = word_cnt;
        if (accept) begin
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                if (word_cnt == CNT_W'(k)) begin
                    pack_nxt[32*k +: 32] = fp_in;
                end
            end
            cnt_nxt = word_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            pack       <= '0;
            word_cnt   <= '0;
            line_out   <= '0;
            line_words <= '0;
            line_valid <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (line_ready) begin
                line_valid <= 1'b0;
            end
            case (state)
                FILL: begin
                    pack     <= pack_nxt;
                    word_cnt <= cnt_nxt;
                    if (cnt_nxt == FULL_CNT) begin
                        // A completing word absorbs a same-cycle flush: no empty line follows.
                        line_out   <= pack_nxt;
                        line_words <= FULL_CNT;
                        line_valid <= 1'b1;
                        pack       <= '0;
                        word_cnt   <= '0;
                        flush_done <= flush;
                    end else if (flush) begin
                        if (cnt_nxt == '0) begin
                            flush_done <= 1'b1;
                        end else if (slot_free) begin
                            line_out   <= pack_nxt;
                            line_words <= cnt_nxt;
                            line_valid <= 1'b1;
                            pack       <= '0;
                            word_cnt   <= '0;
                            flush_done <= 1'b1;
                        end else begin
                            state <= FLUSH_PEND;
                        end
                    end
                end
                FLUSH_PEND: begin
                    if (slot_free) begin
                        line_out   <= pack;
                        line_words <= word_cnt;
                        line_valid <= 1'b1;
                        pack       <= '0;
                        word_cnt   <= '0;
                        flush_done <= 1'b1;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef FP_RESULT_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_in  <= '0;
            stat_lines_out <= '0;
        end else begin
            if (accept) begin
                stat_words_in <= stat_words_in + 32'd1;
            end
            if (line_valid && line_ready) begin
                stat_lines_out <= stat_lines_out + 32'd1;
            end
        end
    end
`endif

endmodule
